dut_resp_monitor: RTL and testbench

//  Sequential response checker on the observe side of a top-level TEST wrapper: the wrapper drives the DUT

---
 rtl/dut_resp_monitor.sv | 233 +++++++++++++++++++++++
 tb/tb_dut_resp_monitor.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_resp_monitor.sv
// -----------------------------------------------------------------------------
// dut_resp_monitor
//
// Checks responses on the observe side of a TEST wrapper. The wrapper drives
// the DUT input (stim), and this block watches the DUT output (out_obs).
// Each time stim toggles, the block waits for a settle window. It then samples
// the synchronised DUT output and compares it with the expected value, which
// is stim, or its inverse when the DUT inverts. Each comparison is reported
// over a valid/ready handshake. Saturating sample and error counters are kept.
//
// Parameters
//   SETTLE_CYC  settle cycles after a stimulus toggle before sampling (1..255)
//   CNT_W       width of sample_cnt / err_cnt
//   INVERT      1: expected = ~stim, 0: expected = stim
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            monitoring enable
//   clear             synchronous clear of both counters
//   stim              stimulus driven into the DUT (synchronous to clk)
//   out_obs           DUT output, asynchronous to clk (2-flop synchronised)
//   res_valid/ready   result handshake
//   res_exp/got/err   expected value, sampled value, mismatch flag
//   sample_cnt        completed comparisons, saturating
//   err_cnt           mismatching comparisons, saturating
//   busy              FSM not idle
// -----------------------------------------------------------------------------
module dut_resp_monitor #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned CNT_W      = 16,
  parameter bit          INVERT     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             stim,
  input  logic             out_obs,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_exp,
  output logic             res_got,
  output logic             res_err,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Settle counter reload: counting SETTLE_CYC-1 down to 0 spends SETTLE_CYC
  // cycles in SETTLE.
  localparam logic [7:0]       RELOAD  = 8'(SETTLE_CYC - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating increment: the counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic             inc);
    logic [CNT_W-1:0] result;
    if (inc && (value != CNT_MAX)) begin
      result = value + CNT_W'(1'b1);
    end else begin
      result = value;
    end
    return result;
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  logic [7:0]       cnt_r;
  logic [7:0]       cnt_next_s;
  logic             pending_r;
  logic             pending_next_s;
  logic             capture_s;
  logic             tgl_s;
  logic             hs_s;
  logic             exp_s;

  logic             sync1_r;
  logic             sync2_r;
  logic             stim_q_r;

  logic             res_valid_r;
  logic             res_exp_r;
  logic             res_got_r;
  logic             res_err_r;
  logic [CNT_W-1:0] sample_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic             busy_r;

  assign tgl_s = stim ^ stim_q_r;
  assign hs_s  = res_valid_r & res_ready;
  assign exp_s = stim ^ INVERT;

  // Two-flop synchroniser for the asynchronous DUT output, plus stimulus history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stim_q_r <= 1'b0;
    end else begin
      sync1_r  <= out_obs;
      sync2_r  <= sync1_r;
      stim_q_r <= stim;
    end
  end

  // Next-state, settle counter and pending-toggle logic.
  always_comb begin
    next_state_s   = state_r;
    cnt_next_s     = cnt_r;
    pending_next_s = pending_r;
    capture_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && tgl_s) begin
          next_state_s = SETTLE;
          cnt_next_s   = RELOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETTLE: begin
        // Abort takes priority. A toggle inside the window restarts the window.
        if (!enable) begin
          next_state_s = IDLE;
        end else if (tgl_s) begin
          cnt_next_s = RELOAD;
        end else if (cnt_r == 8'd0) begin
          next_state_s = SAMPLE;
        end else begin
          cnt_next_s = cnt_r - 8'd1;
        end
      end
      SAMPLE: begin
        capture_s    = 1'b1;
        next_state_s = REPORT;
      end
      REPORT: begin
        // Toggles seen while the result waits are merged into one pending
        // re-check. A toggle in the handshake cycle itself also counts.
        if (hs_s) begin
          pending_next_s = 1'b0;
          if (enable && (pending_r || tgl_s)) begin
            next_state_s = SETTLE;
            cnt_next_s   = RELOAD;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          if (tgl_s) begin
            pending_next_s = 1'b1;
          end else begin
            pending_next_s = pending_r;
          end
        end
      end
      default: begin
        next_state_s   = IDLE;
        cnt_next_s     = 8'd0;
        pending_next_s = 1'b0;
      end
    endcase
  end

  // FSM state, settle counter and pending flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      cnt_r     <= cnt_next_s;
      pending_r <= pending_next_s;
    end
  end

  // Result registers. Valid follows REPORT. The data is captured only in SAMPLE,
  // so it keeps its value through back-pressure and after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_exp_r   <= 1'b0;
      res_got_r   <= 1'b0;
      res_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      res_valid_r <= (next_state_s == REPORT);
      busy_r      <= (next_state_s != IDLE);
      if (capture_s) begin
        res_exp_r <= exp_s;
        res_got_r <= sync2_r;
        res_err_r <= (exp_s != sync2_r);
      end else begin
        res_exp_r <= res_exp_r;
        res_got_r <= res_got_r;
        res_err_r <= res_err_r;
      end
    end
  end

  // Saturating sample/error counters. Clear wins over a same-cycle handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_r <= '0;
      err_cnt_r    <= '0;
    end else if (clear) begin
      sample_cnt_r <= '0;
      err_cnt_r    <= '0;
    end else if (hs_s) begin
      sample_cnt_r <= sat_inc(sample_cnt_r, 1'b1);
      err_cnt_r    <= sat_inc(err_cnt_r, res_err_r);
    end else begin
      sample_cnt_r <= sample_cnt_r;
      err_cnt_r    <= err_cnt_r;
    end
  end

  assign res_valid  = res_valid_r;
  assign res_exp    = res_exp_r;
  assign res_got    = res_got_r;
  assign res_err    = res_err_r;
  assign sample_cnt = sample_cnt_r;
  assign err_cnt    = err_cnt_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_dut_resp_monitor.sv
// -----------------------------------------------------------------------------
// tb_dut_resp_monitor
//
// Directed testbench for dut_resp_monitor. A table of single-toggle
// transactions is followed by hand-written sequences for retrigger,
// back-pressure with pending toggles, clear against a handshake, abort, and
// reset during REPORT. A second instance with CNT_W=2 shares all inputs, and
// its counters show saturation.
// -----------------------------------------------------------------------------
module tb_dut_resp_monitor;

  logic clk = 1'b0;
  logic rst_n, enable, clear, stim, out_obs, res_ready;

  logic        res_valid, res_exp, res_got, res_err, busy;
  logic [15:0] sample_cnt, err_cnt;

  logic        s_valid, s_exp, s_got, s_err, s_busy;
  logic [1:0]  s_sample_cnt, s_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dut_resp_monitor #(.SETTLE_CYC(4), .CNT_W(16), .INVERT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .stim(stim),
    .out_obs(out_obs), .res_valid(res_valid), .res_ready(res_ready),
    .res_exp(res_exp), .res_got(res_got), .res_err(res_err),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .busy(busy)
  );

  dut_resp_monitor #(.SETTLE_CYC(4), .CNT_W(2), .INVERT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .stim(stim),
    .out_obs(out_obs), .res_valid(s_valid), .res_ready(res_ready),
    .res_exp(s_exp), .res_got(s_got), .res_err(s_err),
    .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt), .busy(s_busy)
  );

  typedef struct {
    logic st;
    logic ob;
    int   e;
    int   g;
    int   r;
    int   s;
    int   ec;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic check_res(input string nm, input int e, input int g, input int r);
    check({nm, " res_exp"}, int'(res_exp), e);
    check({nm, " res_got"}, int'(res_got), g);
    check({nm, " res_err"}, int'(res_err), r);
  endtask

  task automatic check_cnt(input string nm, input int s, input int ec);
    check({nm, " sample_cnt"}, int'(sample_cnt), s);
    check({nm, " err_cnt"}, int'(err_cnt), ec);
    check({nm, " sat sample_cnt"}, int'(s_sample_cnt), sat3(s));
    check({nm, " sat err_cnt"}, int'(s_err_cnt), sat3(ec));
  endtask

  // Called in the cycle where a toggle is seen. Waits until res_valid is high
  // and checks that it rises exactly lat cycles later.
  task automatic wait_result(input int lat, input string nm);
    int seen;
    seen = -1;
    for (int i = 1; i <= lat + 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid) begin
        seen = i;
        break;
      end
    end
    check({nm, " latency"}, seen, lat);
  endtask

  task automatic drive(input logic st, input logic ob);
    @(posedge clk);
    #1;
    stim    = st;
    out_obs = ob;
  endtask

  // Counts res_valid and busy highs over n cycles.
  task automatic quiet(input int n, output int nv, output int nb);
    nv = 0;
    nb = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid) nv++;
      if (busy) nb++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nv, nb;
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
    stim = 1'b0; out_obs = 1'b0; res_ready = 1'b0;

    // stim, obs, exp, got, err, sample_cnt, err_cnt (INVERT=1: exp = ~stim)
    vecs[0] = '{1'b1, 1'b0, 0, 0, 0, 1, 0};
    vecs[1] = '{1'b0, 1'b1, 1, 1, 0, 2, 0};
    vecs[2] = '{1'b1, 1'b1, 0, 1, 1, 3, 1};
    vecs[3] = '{1'b0, 1'b0, 1, 0, 1, 4, 2};
    vecs[4] = '{1'b1, 1'b0, 0, 0, 0, 5, 2};
    vecs[5] = '{1'b0, 1'b0, 1, 0, 1, 6, 3};
    vecs[6] = '{1'b1, 1'b1, 0, 1, 1, 7, 4};
    vecs[7] = '{1'b0, 1'b0, 1, 0, 1, 8, 5};

    // Reset values.
    #12;
    check("reset res_valid", int'(res_valid), 0);
    check("reset busy", int'(busy), 0);
    check_res("reset", 0, 0, 0);
    check_cnt("reset", 0, 0);

    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1; res_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Table-driven single transactions with ready tied high.
    for (int k = 0; k < 8; k++) begin
      drive(vecs[k].st, vecs[k].ob);
      wait_result(6, $sformatf("vec%0d", k));
      check_res($sformatf("vec%0d", k), vecs[k].e, vecs[k].g, vecs[k].r);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d valid drop", k), int'(res_valid), 0);
      check($sformatf("vec%0d busy", k), int'(busy), 0);
      check_res($sformatf("vec%0d held", k), vecs[k].e, vecs[k].g, vecs[k].r);
      check_cnt($sformatf("vec%0d", k), vecs[k].s, vecs[k].ec);
    end

    // Clear together with a handshake: clear wins. The result data is untouched.
    drive(1'b1, 1'b0);
    wait_result(6, "clr");
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("clr valid drop", int'(res_valid), 0);
    check_cnt("clr", 0, 0);
    check_res("clr held", 0, 0, 0);

    // Retrigger: a toggle two cycles into SETTLE restarts the window.
    drive(1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("retrig busy", int'(busy), 1);
    @(posedge clk);
    #1;
    stim = 1'b1; out_obs = 1'b0;
    wait_result(6, "retrig");
    check_res("retrig", 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check("retrig valid drop", int'(res_valid), 0);
    check_cnt("retrig", 1, 0);
    quiet(10, nv, nb);
    check("retrig extra results", nv, 0);

    // Back-pressure: result held while toggles accumulate into one pending re-check.
    @(posedge clk);
    #1;
    res_ready = 1'b0; stim = 1'b0; out_obs = 1'b1;
    wait_result(6, "bp");
    check_res("bp", 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        stim = 1'b1; out_obs = 1'b1;
      end else if (i == 2) begin
        stim = 1'b0; out_obs = 1'b0;
      end
      @(negedge clk);
      check($sformatf("bp hold%0d valid", i), int'(res_valid), 1);
      check_res($sformatf("bp hold%0d", i), 1, 1, 0);
    end
    check_cnt("bp hold", 1, 0);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_result(6, "bp pending");
    check_res("bp pending", 1, 0, 1);
    check_cnt("bp first hs", 2, 0);
    @(posedge clk);
    @(negedge clk);
    check("bp valid drop", int'(res_valid), 0);
    check_cnt("bp second hs", 3, 1);
    quiet(10, nv, nb);
    check("bp extra results", nv, 0);
    check("bp idle busy", nb, 0);

    // Abort: enable low during SETTLE. Toggles while disabled are ignored.
    drive(1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("abort settle busy", int'(busy), 1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort busy", int'(busy), 0);
    @(posedge clk);
    #1;
    stim = 1'b0;
    quiet(12, nv, nb);
    check("abort results", nv, 0);
    check("abort busy cycles", nb, 0);
    @(posedge clk);
    #1;
    enable = 1'b1;
    check_cnt("abort", 3, 1);

    // Asynchronous reset while a result waits in REPORT.
    res_ready = 1'b0;
    drive(1'b1, 1'b1);
    wait_result(6, "rstrep");
    check_res("rstrep", 0, 1, 1);
    rst_n = 1'b0;
    #1;
    check("rst valid", int'(res_valid), 0);
    check("rst busy", int'(busy), 0);
    check_res("rst", 0, 0, 0);
    check_cnt("rst", 0, 0);
    stim = 1'b0; out_obs = 1'b0; res_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet(10, nv, nb);
    check("rst lost result", nv, 0);
    check("rst busy after", nb, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
